// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the multiply sequencer state type.
// Imported by the ALU, the multiply sequencer and its testbench.
package alu_pkg;

   localparam logic [2:0] ALU_PASS_B = 3'b000;
   localparam logic [2:0] ALU_ADD    = 3'b010;
   localparam logic [2:0] ALU_SUB    = 3'b011;
   localparam logic [2:0] ALU_AND    = 3'b100;
   localparam logic [2:0] ALU_OR     = 3'b101;
   localparam logic [2:0] ALU_XOR    = 3'b110;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mul_state_t;

endpackage

// File: rtl/alu.sv
// Combinational shared ALU owned by the execute stage; the multiply
// sequencer borrows it for its iterative additions.
module alu
   import alu_pkg::*;
#(
   parameter int BITS = 64
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic [2:0]      cntrl,
   output logic [BITS-1:0] result
);

   always_comb begin
      // NOTE: assign a default before the case so no encoding leaves result unassigned (no latch).
      result = '0;
      case (cntrl)
         ALU_PASS_B: result = b;
         ALU_ADD:    result = a + b;
         ALU_SUB:    result = a - b;
         ALU_AND:    result = a & b;
         ALU_OR:     result = a | b;
         ALU_XOR:    result = a ^ b;
         default:    result = '0;
      endcase
   end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add multiplier (low BITS of the product) that borrows the shared ALU
// via alu_req/alu_gnt. Optional early termination on Q==0: define MUL_EARLY_TERM_EN.
module alu_mul_sequencer
   import alu_pkg::*;
#(
   parameter int BITS = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [BITS-1:0] op_a,
   input  logic [BITS-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [BITS-1:0] result,
   output logic            negative,
   output logic            zero,
   output logic            alu_req,
   input  logic            alu_gnt,
   output logic [BITS-1:0] alu_a,
   output logic [BITS-1:0] alu_b,
   output logic [2:0]      alu_cntrl,
   input  logic [BITS-1:0] alu_result
);

   localparam int CNT_W = $clog2(BITS) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BITS - 1);

   mul_state_t       state_q, state_d;
   logic [BITS-1:0]  m_q, m_d;
   logic [BITS-1:0]  q_q, q_d;
   logic [BITS-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [BITS-1:0]  result_q, result_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             q_zero;

`ifdef MUL_EARLY_TERM_EN
   assign q_zero = (q_q == '0);
`else
   assign q_zero = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      q_d       = q_q;
      acc_d     = acc_q;
      count_d   = count_q;
      result_d  = result_q;
      alu_req   = 1'b0;
      alu_cntrl = ALU_PASS_B;
      alu_a     = '0;
      alu_b     = '0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               m_d     = op_a;
               q_d     = op_b;
               acc_d   = '0;
               count_d = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // Remaining multiplier bits are all zero: ACC already holds the product.
            if (q_zero) begin
               result_d = acc_q;
               state_d  = DONE;
            end else begin
               alu_req   = 1'b1;
               alu_cntrl = ALU_ADD;
               alu_a     = acc_q;
               alu_b     = q_q[0] ? m_q : '0;
               // Without a grant nothing moves, so the ALU operands stay stable for the retry.
               if (alu_gnt) begin
                  acc_d   = alu_result;
                  m_d     = m_q << 1;
                  q_d     = q_q >> 1;
                  count_d = count_q + CNT_W'(1);
                  if (count_q == LAST_ITER) begin
                     result_d = alu_result;
                     state_d  = DONE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         m_q      <= '0;
         q_q      <= '0;
         acc_q    <= '0;
         count_q  <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q  <= state_d;
         m_q      <= m_d;
         q_q      <= q_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign negative = result_q[BITS-1];
   assign zero     = (result_q == '0);

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer driving the real shared ALU, with a
// product/latency reference model computed from plain arithmetic and a grant pattern.
module tb_alu_mul_sequencer;
   import alu_pkg::*;

   localparam int BITS = 64;
`ifdef MUL_EARLY_TERM_EN
   localparam bit EARLY_TERM = 1'b1;
`else
   localparam bit EARLY_TERM = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset, start, alu_gnt;
   logic [BITS-1:0] op_a, op_b, result, alu_a, alu_b, alu_result;
   logic            busy, done, negative, zero, alu_req;
   logic [2:0]      alu_cntrl;

   int vectors = 0;
   int miscompares = 0;
   bit gnt_pat [0:511];

   always #5 clk = ~clk;

   alu_mul_sequencer #(.BITS(BITS)) dut (
      .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .result(result), .negative(negative), .zero(zero),
      .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
      .alu_cntrl(alu_cntrl), .alu_result(alu_result)
   );

   alu #(.BITS(BITS)) u_alu (
      .a(alu_a), .b(alu_b), .cntrl(alu_cntrl), .result(alu_result)
   );

   function automatic int bitlen(input logic [BITS-1:0] v);
      int n = 0;
      for (int i = 0; i < BITS; i++) if (v[i]) n = i + 1;
      return n;
   endfunction

   // mode 0: always granted; 1: granted on even cycles; 2: random, forced on late
   task automatic fill_gnt(input int mode);
      for (int c = 0; c < 512; c++) begin
         case (mode)
            0:       gnt_pat[c] = 1'b1;
            1:       gnt_pat[c] = (c % 2 == 0);
            default: gnt_pat[c] = (c >= 300) ? 1'b1 : ($urandom_range(0, 1) == 1);
         endcase
      end
   endtask

   // Cycle (start accepted = cycle 0) on which done is expected.
   function automatic int model_done_cycle(input logic [BITS-1:0] b);
      int iters = EARLY_TERM ? bitlen(b) : BITS;
      int g = 0;
      if (iters == 0) return 2;
      for (int c = 1; c < 512; c++) begin
         if (gnt_pat[c]) g++;
         if (g == iters) return (iters == BITS) ? c + 1 : c + 2;
      end
      return 511;
   endfunction

   // Called right after start was driven in cycle 0; returns at the negedge inside the done cycle.
   task automatic watch(input string name, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                        input bit hold);
      logic [BITS-1:0] exp_res, sa, sb;
      logic [2:0]      sc;
      int              exp_cyc;
      bit              prev_den;
      exp_res  = a * b;
      exp_cyc  = model_done_cycle(b);
      prev_den = 1'b0;
      sa = '0; sb = '0; sc = '0;
      for (int cyc = 1; cyc <= exp_cyc; cyc++) begin
         @(negedge clk);
         if (prev_den) begin
            vectors++;
            if (alu_a !== sa || alu_b !== sb || alu_cntrl !== sc) begin
               miscompares++;
               $display("FAIL %s stable@%0d: a=%h b=%h c=%0d, expected a=%h b=%h c=%0d",
                        name, cyc, alu_a, alu_b, alu_cntrl, sa, sb, sc);
            end
         end
         if (cyc < exp_cyc) begin
            vectors++;
            if (done !== 1'b0 || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL %s run@%0d: done=%b busy=%b, expected done=0 busy=1",
                        name, cyc, done, busy);
            end
         end else begin
            vectors++;
            if (done !== 1'b1 || busy !== 1'b0 || alu_req !== 1'b0) begin
               miscompares++;
               $display("FAIL %s done@%0d: done=%b busy=%b req=%b, expected 1 0 0",
                        name, cyc, done, busy, alu_req);
            end
            vectors++;
            if (result !== exp_res || zero !== (exp_res == '0) || negative !== exp_res[BITS-1]) begin
               miscompares++;
               $display("FAIL %s result: got %h z=%b n=%b, expected %h z=%b n=%b",
                        name, result, zero, negative, exp_res, (exp_res == '0), exp_res[BITS-1]);
            end
         end
         prev_den = alu_req && !gnt_pat[cyc];
         sa = alu_a; sb = alu_b; sc = alu_cntrl;
         alu_gnt = gnt_pat[cyc];
         if (!hold) start = 1'b0;
         else if (cyc < exp_cyc) begin
            op_a = {$urandom, $urandom};
            op_b = {$urandom, $urandom};
         end
      end
   endtask

   task automatic test_single(input string name, input logic [BITS-1:0] a,
                              input logic [BITS-1:0] b, input int mode);
      logic [BITS-1:0] exp_res;
      exp_res = a * b;
      fill_gnt(mode);
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b; alu_gnt = gnt_pat[0];
      watch(name, a, b, 1'b0);
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
         miscompares++;
         $display("FAIL %s after: done=%b busy=%b result=%h, expected 0 0 %h",
                  name, done, busy, result, exp_res);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; alu_gnt = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b1 || negative !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_status: busy=%b done=%b result=%h zero=%b neg=%b, expected 0 0 0 1 0",
                  busy, done, result, zero, negative);
      end
      vectors++;
      if (alu_req !== 1'b0 || alu_a !== '0 || alu_b !== '0 || alu_cntrl !== ALU_PASS_B) begin
         miscompares++;
         $display("FAIL reset_alu: req=%b a=%h b=%h c=%0d, expected 0 0 0 %0d",
                  alu_req, alu_a, alu_b, alu_cntrl, ALU_PASS_B);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic;
      test_single("mul_7x6", 64'd7, 64'd6, 0);
      test_single("mul_ones_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
      test_single("mul_12345x0", 64'd12345, 64'd0, 0);
   endtask

   task automatic test_gnt_toggle;
      test_single("mul_3x5_toggle", 64'd3, 64'd5, 1);
   endtask

   task automatic test_random;
      logic [BITS-1:0] a, b;
      for (int i = 0; i < 8; i++) begin
         a = {$urandom, $urandom};
         b = (i % 2 == 0) ? {$urandom, $urandom} : BITS'($urandom_range(0, 1000));
         test_single($sformatf("rand_%0d", i), a, b, 2);
      end
   endtask

   task automatic test_back_to_back;
      fill_gnt(0);
      @(negedge clk);
      start = 1'b1; op_a = 64'd2; op_b = 64'd3; alu_gnt = 1'b1;
      watch("b2b_first", 64'd2, 64'd3, 1'b1);
      op_a = 64'd4; op_b = 64'd5;
      watch("b2b_second", 64'd4, 64'd5, 1'b0);
   endtask

   task automatic test_reset_mid_run;
      bit saw_done;
      @(negedge clk);
      start = 1'b1; op_a = 64'd12345; op_b = 64'd678; alu_gnt = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         vectors++;
         if (done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_run@%0d: done=%b busy=%b, expected 0 1", cyc, done, busy);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || alu_req !== 1'b0 ||
          alu_cntrl !== ALU_PASS_B || alu_a !== '0 || alu_b !== '0) begin
         miscompares++;
         $display("FAIL midrst_state: busy=%b done=%b result=%h req=%b c=%0d a=%h b=%h, expected all idle",
                  busy, done, result, alu_req, alu_cntrl, alu_a, alu_b);
      end
      reset = 1'b0;
      saw_done = 1'b0;
      repeat (70) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      end
      vectors++;
      if (saw_done) begin
         miscompares++;
         $display("FAIL midrst_quiet: done/busy seen after abandoned op, expected none");
      end
      test_single("mul_9x9_after_reset", 64'd9, 64'd9, 0);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_gnt_toggle;
      test_random;
      test_back_to_back;
      test_reset_mid_run;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
